dark_mixer: RTL and testbench
=============================

DARK_MIXER -- requirements
Module: dark_mixer

Interface
- REQ-001: Parameter CH, default 3: number of colour channels per pixel.
- REQ-002: Parameter W, default 8: bits per channel.
- REQ-003: Parameter FW, default 4: fade resolution; full strength M = 2^FW.
- REQ-004: Parameter STEP, default 1: fade increment/decrement per frame, 1..M.
- REQ-005: clk_i  input  1  pixel clock; one clock domain only; all logic on posedge.
- REQ-006: rst_i  input  1  reset; synchronous and active-high.
- REQ-007: hs_i / vs_i / de_i  input  1 each  video timing for the pixel on data_i.
- REQ-008: data_i  input  CH*W  pixel; channel 0 in the LSBs.
- REQ-009: blk_x_i  input  1  per-pixel block decision, aligned with data_i.
- REQ-010: mode_i  input  2  00 = invert where blk_x; 01 = none; 10 = all; 11 = invert where ~blk_x.
- REQ-011: bypass_i  input  1  pass data_i unmodified, with the same latency.
- REQ-012: hs_o / vs_o / de_o  output  1 each  timing delayed to match data_o.
- REQ-013: data_o  output  CH*W  mixed pixel.
- REQ-014: fade_o  output  FW+1  current fade strength a, 0..M.
- REQ-015: busy_o  output  1  high while a != target.
- REQ-016: frame_o  output  1  toggles on every vs_i rising edge (heartbeat).

Function
- REQ-017: A vs_i rising edge is vs_i=1 with the previous-cycle vs_i=0, registered internally.
- REQ-018: mode_i and bypass_i are latched into mode_q and byp_q only on a vs_i rising edge; mid-frame changes have no effect until the next edge.
- REQ-019: target = 0 when mode_q = 01, else M.
- REQ-020: On each vs_i rising edge, after mode_q updates, a moves STEP toward target; a saturates exactly at target with no overshoot when STEP does not divide M.
- REQ-021: a is constant between vs_i rising edges.
- REQ-022: Per-pixel select s = blk_x_i (00), 0 (01), 1 (10), ~blk_x_i (11), evaluated with mode_q.
- REQ-023: Per channel with pixel value p, effective weight e = (s ? a : 0).
- REQ-024: Output channel = (p*(M-e) + ((2^W-1)-p)*e) >> FW.
- REQ-025: Intermediate width is at least W+FW+1 bits with no overflow; e=0 yields p exactly and e=M yields 2^W-1-p exactly.
- REQ-026: When byp_q=1, data_o = data_i delayed, regardless of mode and a.
- REQ-027: Fixed latency is 3 clk_i cycles from data_i/blk_x_i/timing inputs to data_o and hs_o/vs_o/de_o.
  - Stage 1 registers inputs and s.
  - Stage 2 forms the products.
  - Stage 3 forms the sum and shift.
- REQ-028: The pipeline advances every cycle; there is no stall or backpressure.
- REQ-029: When de_i=0, data still flows through the pipeline; data_o is don't-care but deterministic (the same formula applies).
- REQ-030: The a used for a pixel is the value captured at stage 1, so a change at a vs_i edge affects only pixels entering on or after that cycle.
- REQ-031: busy_o = (a != target), registered, and updates in the cycle after a changes.

Reset
- REQ-032: While rst_i=1 on a clock edge, the following are cleared:
  - a = 0, mode_q = 01, byp_q = 0.
  - vs_i history = 0, frame_o = 0, busy_o = 0.
  - All pipeline stages, including data_o, hs_o, vs_o and de_o, are 0.
- REQ-033: A vs_i rising edge coincident with rst_i=1 is ignored.
- REQ-034: Reset asserted mid-fade or mid-frame takes effect on that edge; after release, data_o is valid from the 3rd cycle on.

Verification
- REQ-035: Reset with default parameters -> data_o=0, fade_o=0, busy_o=0, frame_o=0; 3 cycles after release with data_i=0x123456, data_o=0x123456.
- REQ-036: mode_i=10 latched at a vs_i edge after reset -> fade_o=1 and busy_o=1.
  - After 8 frame edges, data_i=0x000000 gives data_o=0x7F7F7F.
  - After 16 edges, fade_o=16 and busy_o=0; data_i=0x123456 gives data_o=0xEDCBA9.
- REQ-037: mode_i=00 with fade_o=16 -> blk_x_i=1 with 0x123456 gives 0xEDCBA9; blk_x_i=0 gives 0x123456; mode 11 gives the opposite.
- REQ-038: STEP=5, M=16, from a=0 with mode 10 -> fade_o sequence 5, 10, 15, 16, 16; then with mode 01 -> 11, 6, 1, 0.
- REQ-039: mode_i and bypass_i changed mid-frame -> data_o unchanged until the next vs_i rising edge, then the new mode applies starting with the pixel entering on that cycle; bypass_i=1 gives data_o = data_i delayed 3 cycles.
- REQ-040: rst_i pulsed for 1 cycle at fade_o=8 mid-frame -> the next edge gives fade_o=0 and outputs 0; a subsequent mode 10 edge gives fade_o=1.

Source files
------------

// File: rtl/dark_mixer.sv
// dark_mixer -- per-pixel "dark mode" colour inverter with a frame-rate fade.
//
// Each channel p of the incoming pixel is blended toward its complement
// (2^W-1-p) with weight e/M, where e is the current fade strength a for
// selected pixels and 0 otherwise. The fade strength walks STEP per frame
// (vs_i rising edge) toward a target chosen by the latched mode.
//
// Ports:
//   clk_i      pixel clock (single domain, posedge)
//   rst_i      synchronous, active-high reset
//   hs_i/vs_i/de_i  video timing for the pixel on data_i
//   data_i     CH*W pixel, channel 0 in the LSBs
//   blk_x_i    per-pixel block decision aligned with data_i
//   mode_i     00 invert where blk_x, 01 none, 10 all, 11 invert where ~blk_x
//   bypass_i   pass data_i unmodified (same latency)
//   hs_o/vs_o/de_o  timing delayed to match data_o (3 cycles)
//   data_o     mixed pixel
//   fade_o     current fade strength a, 0..2^FW
//   busy_o     high while a != target (registered)
//   frame_o    toggles on every vs_i rising edge
module dark_mixer #(
    parameter int CH   = 3,
    parameter int W    = 8,
    parameter int FW   = 4,
    parameter int STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            hs_i,
    input  logic            vs_i,
    input  logic            de_i,
    input  logic [CH*W-1:0] data_i,
    input  logic            blk_x_i,
    input  logic [1:0]      mode_i,
    input  logic            bypass_i,
    output logic            hs_o,
    output logic            vs_o,
    output logic            de_o,
    output logic [CH*W-1:0] data_o,
    output logic [FW:0]     fade_o,
    output logic            busy_o,
    output logic            frame_o
);

    localparam int            PW     = W + FW + 1;     // product / sum width
    localparam logic [FW:0]   M_V    = (FW+1)'(1 << FW);
    localparam logic [FW:0]   STEP_V = (FW+1)'(STEP);
    localparam logic [W-1:0]  MAXP   = '1;

    typedef enum logic [1:0] {
        MODE_BLK  = 2'b00,
        MODE_NONE = 2'b01,
        MODE_ALL  = 2'b10,
        MODE_NBLK = 2'b11
    } mode_e;

    // ------------------------------------------------------------------
    // Frame-rate control state
    // ------------------------------------------------------------------
    logic        vs_q;
    logic        frame_q;
    mode_e       mode_q;
    logic        byp_q;
    logic [FW:0] a_q;
    logic        busy_q;

    logic        vs_rise;
    mode_e       mode_n;
    logic        byp_n;
    logic [FW:0] tgt_n;
    logic [FW:0] tgt_q;
    logic [FW:0] a_n;
    logic [FW+1:0] a_up;
    logic        s_n;

    // The values that take effect on a vs_i edge are computed combinationally
    // so the pixel entering on that same cycle already sees the new mode/fade.
    // NOTE: every signal in this block gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        vs_rise = vs_i & ~vs_q;
        mode_n  = mode_q;
        byp_n   = byp_q;
        a_n     = a_q;
        a_up    = {1'b0, a_q} + {1'b0, STEP_V};
        if (vs_rise) begin
            mode_n = mode_e'(mode_i);
            byp_n  = bypass_i;
        end
        tgt_n = (mode_n == MODE_NONE) ? '0 : M_V;
        tgt_q = (mode_q == MODE_NONE) ? '0 : M_V;
        if (vs_rise) begin
            // Saturate exactly at the target when STEP does not divide M.
            if (a_q < tgt_n) begin
                a_n = (a_up >= {1'b0, tgt_n}) ? tgt_n : a_up[FW:0];
            end else if (a_q > tgt_n) begin
                a_n = ((a_q - tgt_n) > STEP_V) ? (a_q - STEP_V) : tgt_n;
            end
        end
        unique case (mode_n)
            MODE_BLK:  s_n = blk_x_i;
            MODE_NONE: s_n = 1'b0;
            MODE_ALL:  s_n = 1'b1;
            MODE_NBLK: s_n = ~blk_x_i;
            default:   s_n = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vs_q    <= 1'b0;
            frame_q <= 1'b0;
            mode_q  <= MODE_NONE;
            byp_q   <= 1'b0;
            a_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            vs_q    <= vs_i;
            if (vs_rise) frame_q <= ~frame_q;
            mode_q  <= mode_n;
            byp_q   <= byp_n;
            a_q     <= a_n;
            // Compares the registered a, so busy follows a change one cycle late.
            busy_q  <= (a_q != tgt_q);
        end
    end

    assign fade_o  = a_q;
    assign busy_o  = busy_q;
    assign frame_o = frame_q;

    // ------------------------------------------------------------------
    // Stage 1: register pixel, timing, effective weight and bypass
    // ------------------------------------------------------------------
    logic [CH*W-1:0] s1_data;
    logic [FW:0]     s1_e;
    logic            s1_byp, s1_hs, s1_vs, s1_de;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_data <= '0;
            s1_e    <= '0;
            s1_byp  <= 1'b0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s1_de   <= 1'b0;
        end else begin
            s1_data <= data_i;
            s1_e    <= s_n ? a_n : '0;
            s1_byp  <= byp_n;
            s1_hs   <= hs_i;
            s1_vs   <= vs_i;
            s1_de   <= de_i;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: per-channel products p*(M-e) and (MAX-p)*e
    // ------------------------------------------------------------------
    logic [CH-1:0][PW-1:0] s2_keep;
    logic [CH-1:0][PW-1:0] s2_inv;
    logic [CH*W-1:0]       s2_data;
    logic                  s2_byp, s2_hs, s2_vs, s2_de;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the product array is a pipeline stage, not storage, so it is
            // cleared with the rest of the datapath to keep outputs defined.
            s2_keep <= '0;
            s2_inv  <= '0;
            s2_data <= '0;
            s2_byp  <= 1'b0;
            s2_hs   <= 1'b0;
            s2_vs   <= 1'b0;
            s2_de   <= 1'b0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                s2_keep[c] <= PW'(s1_data[c*W +: W]) * PW'(M_V - s1_e);
                s2_inv[c]  <= PW'(MAXP - s1_data[c*W +: W]) * PW'(s1_e);
            end
            s2_data <= s1_data;
            s2_byp  <= s1_byp;
            s2_hs   <= s1_hs;
            s2_vs   <= s1_vs;
            s2_de   <= s1_de;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: sum and shift, bypass select, output register
    // ------------------------------------------------------------------
    logic [CH*W-1:0] mix_n;

    // The sum never exceeds (2^W-1)*M, so PW bits cannot overflow and the
    // endpoints e=0 / e=M come out exact.
    always_comb begin
        mix_n = '0;
        for (int c = 0; c < CH; c++) begin
            mix_n[c*W +: W] = W'((s2_keep[c] + s2_inv[c]) >> FW);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o <= '0;
            hs_o   <= 1'b0;
            vs_o   <= 1'b0;
            de_o   <= 1'b0;
        end else begin
            data_o <= s2_byp ? s2_data : mix_n;
            hs_o   <= s2_hs;
            vs_o   <= s2_vs;
            de_o   <= s2_de;
        end
    end

endmodule

// File: tb/tb_dark_mixer.sv
module tb_dark_mixer;

    localparam int CH = 3;
    localparam int W  = 8;
    localparam int FW = 4;
    localparam int M  = 16;
    localparam int DW = CH * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst  = 1'b1;
    logic          hs   = 1'b0;
    logic          vs   = 1'b0;
    logic          de   = 1'b0;
    logic          blk  = 1'b0;
    logic          byp  = 1'b0;
    logic [1:0]    mode = 2'b01;
    logic [DW-1:0] din  = '0;

    logic          hs_o, vs_o, de_o, busy_o, frame_o;
    logic [DW-1:0] data_o;
    logic [FW:0]   fade_o;

    logic          hs5, vs5, de5, busy5, frame5;
    logic [DW-1:0] data5;
    logic [FW:0]   fade5;

    dark_mixer #(.CH(CH), .W(W), .FW(FW), .STEP(1)) u_dut (
        .clk_i(clk), .rst_i(rst), .hs_i(hs), .vs_i(vs), .de_i(de),
        .data_i(din), .blk_x_i(blk), .mode_i(mode), .bypass_i(byp),
        .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .data_o(data_o),
        .fade_o(fade_o), .busy_o(busy_o), .frame_o(frame_o)
    );

    dark_mixer #(.CH(CH), .W(W), .FW(FW), .STEP(5)) u_dut5 (
        .clk_i(clk), .rst_i(rst), .hs_i(hs), .vs_i(vs), .de_i(de),
        .data_i(din), .blk_x_i(blk), .mode_i(mode), .bypass_i(byp),
        .hs_o(hs5), .vs_o(vs5), .de_o(de5), .data_o(data5),
        .fade_o(fade5), .busy_o(busy5), .frame_o(frame5)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          hs;
        logic          vs;
        logic          de;
    } exp_t;

    typedef struct {
        logic [1:0]    mode;
        logic          blk;
        logic [DW-1:0] pix;
        logic [DW-1:0] exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (STEP = 1 instance)
    exp_t       q[$];
    int         m_a     = 0;
    logic [1:0] m_mode  = 2'b01;
    logic       m_byp   = 1'b0;
    logic       m_vsp   = 1'b0;
    logic       m_frame = 1'b0;
    logic       m_busy  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tgt(input logic [1:0] md);
        return (md == 2'b01) ? 0 : M;
    endfunction

    // Blend each channel toward its complement by e/M, straight from the formula.
    function automatic logic [DW-1:0] mix_model(input logic [DW-1:0] p, input logic b,
                                                input logic [1:0] md, input int a,
                                                input logic bp);
        logic [DW-1:0] r;
        logic          sel;
        int            e, pc, v;
        if (bp) return p;
        case (md)
            2'b00:   sel = b;
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            default: sel = ~b;
        endcase
        e = sel ? a : 0;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            pc = int'(p[c*W +: W]);
            v  = (pc * (M - e) + (255 - pc) * e) / M;
            r[c*W +: W] = v[W-1:0];
        end
        return r;
    endfunction

    // One clock: update the model for the inputs now driven, let the edge pass,
    // then compare everything on the falling edge.
    task automatic step();
        exp_t ex;
        int   t;
        if (rst) begin
            m_a = 0; m_mode = 2'b01; m_byp = 1'b0; m_vsp = 1'b0;
            m_frame = 1'b0; m_busy = 1'b0;
            q.delete();
            q.push_back('0);
            q.push_back('0);
        end else begin
            m_busy = (m_a != tgt(m_mode));
            if (vs && !m_vsp) begin
                m_mode  = mode;
                m_byp   = byp;
                m_frame = ~m_frame;
                t = tgt(m_mode);
                if (m_a < t)      m_a = (m_a + 1 > t) ? t : m_a + 1;
                else if (m_a > t) m_a = (m_a - 1 < t) ? t : m_a - 1;
            end
            m_vsp   = vs;
            ex.data = mix_model(din, blk, m_mode, m_a, m_byp);
            ex.hs   = hs;
            ex.vs   = vs;
            ex.de   = de;
            q.push_back(ex);
        end
        @(negedge clk);
        if (rst) begin
            check("reset_data", 64'(data_o), 64'(0));
            check("reset_timing", 64'({hs_o, vs_o, de_o}), 64'(0));
        end
        check("fade", 64'(fade_o), 64'(m_a));
        check("busy", 64'(busy_o), 64'(m_busy));
        check("frame", 64'(frame_o), 64'(m_frame));
        if (q.size() == 3) begin
            ex = q.pop_front();
            check("pipe_data", 64'(data_o), 64'(ex.data));
            check("pipe_timing", 64'({hs_o, vs_o, de_o}), 64'({ex.hs, ex.vs, ex.de}));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic frame_edge(input logic [1:0] md, input logic bp);
        mode = md;
        byp  = bp;
        vs   = 1'b1;
        step();
        vs   = 1'b0;
        step();
    endtask

    vec_t vecs[8];
    int   up5[5]   = '{5, 10, 15, 16, 16};
    int   down5[4] = '{11, 6, 1, 0};

    initial begin
        vecs[0] = '{2'b00, 1'b1, 24'h123456, 24'hEDCBA9};
        vecs[1] = '{2'b00, 1'b0, 24'h123456, 24'h123456};
        vecs[2] = '{2'b11, 1'b1, 24'h123456, 24'h123456};
        vecs[3] = '{2'b11, 1'b0, 24'h123456, 24'hEDCBA9};
        vecs[4] = '{2'b10, 1'b0, 24'h000000, 24'hFFFFFF};
        vecs[5] = '{2'b00, 1'b1, 24'hFFFFFF, 24'h000000};
        vecs[6] = '{2'b00, 1'b0, 24'hA5A5A5, 24'hA5A5A5};
        vecs[7] = '{2'b10, 1'b1, 24'h80FF00, 24'h7F00FF};

        // Reset values and pass-through latency after release
        do_reset();
        check("reset_fade", 64'(fade_o), 64'(0));
        din = 24'h123456;
        idle(3);
        check("release_passthru", 64'(data_o), 64'h123456);

        // Fade in with mode 10
        frame_edge(2'b10, 1'b0);
        check("first_edge_fade", 64'(fade_o), 64'(1));
        check("first_edge_busy", 64'(busy_o), 64'(1));
        repeat (7) frame_edge(2'b10, 1'b0);
        check("half_fade", 64'(fade_o), 64'(8));
        din = 24'h000000;
        idle(3);
        check("half_mix", 64'(data_o), 64'h7F7F7F);
        repeat (8) frame_edge(2'b10, 1'b0);
        check("full_fade", 64'(fade_o), 64'(16));
        check("full_busy", 64'(busy_o), 64'(0));
        din = 24'h123456;
        idle(3);
        check("full_mix", 64'(data_o), 64'hEDCBA9);

        // Mode table at full strength
        for (int i = 0; i < 8; i++) begin
            frame_edge(vecs[i].mode, 1'b0);
            din = vecs[i].pix;
            blk = vecs[i].blk;
            idle(3);
            check($sformatf("vec%0d", i), 64'(data_o), 64'(vecs[i].exp));
        end

        // Mid-frame mode/bypass change has no effect until the next edge
        frame_edge(2'b00, 1'b0);
        din  = 24'h0F0F0F;
        blk  = 1'b1;
        mode = 2'b01;
        byp  = 1'b1;
        idle(4);
        check("midframe_hold", 64'(data_o), 64'hF0F0F0);
        frame_edge(2'b01, 1'b1);
        step();
        check("bypass_edge_pixel", 64'(data_o), 64'h0F0F0F);
        check("bypass_fade", 64'(fade_o), 64'(15));
        frame_edge(2'b10, 1'b0);
        idle(3);

        // Reset pulse mid-frame at fade 8
        do_reset();
        repeat (8) frame_edge(2'b10, 1'b0);
        check("pre_rst_fade", 64'(fade_o), 64'(8));
        din = 24'h3C5A7E;
        idle(2);
        do_reset();
        check("rst_pulse_fade", 64'(fade_o), 64'(0));
        check("rst_pulse_data", 64'(data_o), 64'(0));
        frame_edge(2'b10, 1'b0);
        check("post_rst_fade", 64'(fade_o), 64'(1));

        // STEP = 5 saturation, both directions
        do_reset();
        for (int i = 0; i < 5; i++) begin
            frame_edge(2'b10, 1'b0);
            check($sformatf("step5_up%0d", i), 64'(fade5), 64'(up5[i]));
        end
        for (int i = 0; i < 4; i++) begin
            frame_edge(2'b01, 1'b0);
            check($sformatf("step5_dn%0d", i), 64'(fade5), 64'(down5[i]));
        end

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            vs  = ((i % 40) < 3);
            hs  = 1'($urandom);
            de  = 1'($urandom);
            blk = 1'($urandom);
            din = DW'($urandom);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 29) == 0) byp  = 1'($urandom);
            rst = (i == 1000);
            step();
        end
        rst = 1'b0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
